// File: rtl/fpga_io_regs_pkg.sv
// fpga_io_regs_pkg: register offsets, ID bytes and interrupt bit positions for the FPGA I/O block.
package fpga_io_regs_pkg;
  localparam logic [11:0] A_LED       = 12'h000;
  localparam logic [11:0] A_BTN       = 12'h008;
  localparam logic [11:0] A_BTN_RAW   = 12'h00C;
  localparam logic [11:0] A_CNT1HZ    = 12'h010;
  localparam logic [11:0] A_CNT100HZ  = 12'h014;
  localparam logic [11:0] A_CYCLE     = 12'h018;
  localparam logic [11:0] A_PRESCALE  = 12'h01C;
  localparam logic [11:0] A_PSCNTR    = 12'h020;
  localparam logic [11:0] A_COMPARE   = 12'h024;
  localparam logic [11:0] A_INT_EN    = 12'h028;
  localparam logic [11:0] A_INT_STAT  = 12'h02C;
  localparam logic [11:0] A_EDGE_RISE = 12'h030;
  localparam logic [11:0] A_EDGE_FALL = 12'h034;
  localparam logic [11:0] A_MISC      = 12'h04C;
  localparam logic [11:0] A_ID_BASE   = 12'hFD0;
  localparam int INT_BTN_BIT = 0;
  localparam int INT_CMP_BIT = 16;
  // Byte i is the ID word at A_ID_BASE + 4*i: PID4..7, PID0..3, CID0..3; padded so any 4-bit index is in range.
  localparam logic [127:0] ID_TABLE = {32'h0,
    8'hB1, 8'h05, 8'hF0, 8'h0D, 8'h00, 8'h0B, 8'hB8, 8'h51, 8'h00, 8'h00, 8'h00, 8'h04};
  function automatic logic [7:0] id_byte(input logic [3:0] i);
    return ID_TABLE[{i, 3'b000} +: 8];
  endfunction
endpackage

// File: rtl/fpga_io_btn_debounce.sv
// fpga_io_btn_debounce: synchronises one button, debounces it over 100 Hz ticks and flags debounced edges.
module fpga_io_btn_debounce #(
  parameter int DEBOUNCE_TICKS = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  input  logic tick,
  output logic raw,
  output logic db,
  output logic rise,
  output logic fall
);
  localparam logic [3:0] LAST = 4'(DEBOUNCE_TICKS == 0 ? 0 : DEBOUNCE_TICKS - 1);
  logic s1, upd;
  logic [3:0] cnt;
  // Edge flags are combinational so they coincide with the cycle db changes.
  assign upd  = (raw != db) & ((DEBOUNCE_TICKS == 0) | (tick & (cnt == LAST)));
  assign rise = upd & raw;
  assign fall = upd & ~raw;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1  <= 1'b0;
      raw <= 1'b0;
      db  <= 1'b0;
      cnt <= '0;
    end else begin
      s1  <= btn;
      raw <= s1;
      db  <= upd ? raw : db;
      cnt <= (raw == db || upd) ? 4'd0 : cnt + 4'(tick);
    end
endmodule

// File: rtl/fpga_io_regs_gen.sv
// fpga_io_regs_gen: APB register block for LEDs, debounced buttons, 100 Hz/1 Hz/cycle counters and interrupts.
module fpga_io_regs_gen
  import fpga_io_regs_pkg::*;
#(
  parameter int N_LED          = 8,
  parameter int N_BTN          = 2,
  parameter int N_MISC         = 10,
  parameter int DEBOUNCE_TICKS = 3
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [11:2]       PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  input  logic              clk_100hz,
  input  logic [N_BTN-1:0]  buttons,
  output logic [N_LED-1:0]  leds,
  output logic [N_MISC-1:0] fpga_misc,
  output logic              irq
);
  localparam logic [31:0] INT_MASK = (32'd1 << INT_CMP_BIT) | (((32'd1 << N_BTN) - 32'd1) << INT_BTN_BIT);
  logic [11:0] addr;
  logic wr, tick, cmp_hit;
  logic [2:0] hz;
  logic [6:0] div;
  logic [N_BTN-1:0] raw, db, rise, fall, edge_rise, edge_fall;
  logic [31:0] cnt1hz, cnt100hz, cycle, prescale, pscntr, compare, int_en, int_stat, set, rdata;
  assign addr    = {PADDR, 2'b00};
  assign wr      = PSEL & PWRITE & PENABLE;
  assign tick    = hz[1] & ~hz[2];
  assign PREADY  = 1'b1;
  assign PSLVERR = 1'b0;
  function automatic logic hit(input logic [11:0] a);
    return wr && addr == a;
  endfunction
  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    fpga_io_btn_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_deb (
      .clk(PCLK), .rst_n(PRESETn), .btn(buttons[i]), .tick(tick),
      .raw(raw[i]), .db(db[i]), .rise(rise[i]), .fall(fall[i])
    );
  end
  // Compare fires only on a hardware increment; a software CYCLE write suppresses it.
  assign cmp_hit = !hit(A_CYCLE) && pscntr == 32'd0 && cycle + 32'd1 == compare;
  assign set = (32'(cmp_hit) << INT_CMP_BIT) | (32'((rise & edge_rise) | (fall & edge_fall)) << INT_BTN_BIT);
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      hz        <= '0;
      leds      <= '0;
      fpga_misc <= '1;
      edge_rise <= '0;
      edge_fall <= '0;
      cnt1hz    <= '0;
      cnt100hz  <= '0;
      div       <= '0;
      cycle     <= '0;
      prescale  <= '0;
      pscntr    <= '0;
      compare   <= '0;
      int_en    <= '0;
      int_stat  <= '0;
      irq       <= 1'b0;
    end else begin
      hz <= {hz[1:0], clk_100hz};
      if (hit(A_LED)) leds <= PWDATA[N_LED-1:0];
      if (hit(A_MISC)) fpga_misc <= PWDATA[N_MISC-1:0];
      if (hit(A_EDGE_RISE)) edge_rise <= PWDATA[N_BTN-1:0];
      if (hit(A_EDGE_FALL)) edge_fall <= PWDATA[N_BTN-1:0];
      if (hit(A_PRESCALE)) prescale <= PWDATA;
      if (hit(A_COMPARE)) compare <= PWDATA;
      if (hit(A_INT_EN)) int_en <= PWDATA & INT_MASK;
      cnt100hz <= hit(A_CNT100HZ) ? PWDATA : cnt100hz + 32'(tick);
      if (hit(A_CNT1HZ)) begin
        cnt1hz <= PWDATA;
        div    <= '0;
      end else if (tick) begin
        cnt1hz <= cnt1hz + 32'(div == 7'd99);
        div    <= div == 7'd99 ? 7'd0 : div + 7'd1;
      end
      pscntr   <= (hit(A_PRESCALE) || hit(A_PSCNTR)) ? PWDATA : pscntr == 32'd0 ? prescale : pscntr - 32'd1;
      cycle    <= hit(A_CYCLE) ? PWDATA : cycle + 32'(pscntr == 32'd0);
      int_stat <= ((int_stat & ~(hit(A_INT_STAT) ? PWDATA : 32'd0)) | set) & INT_MASK;
      irq      <= |(int_stat & int_en);
    end
  always_comb begin
    rdata = '0;
    case (addr)
      A_LED:       rdata = 32'(leds);
      A_BTN:       rdata = 32'(db);
      A_BTN_RAW:   rdata = 32'(raw);
      A_CNT1HZ:    rdata = cnt1hz;
      A_CNT100HZ:  rdata = cnt100hz;
      A_CYCLE:     rdata = cycle;
      A_PRESCALE:  rdata = prescale;
      A_PSCNTR:    rdata = pscntr;
      A_COMPARE:   rdata = compare;
      A_INT_EN:    rdata = int_en;
      A_INT_STAT:  rdata = int_stat;
      A_EDGE_RISE: rdata = 32'(edge_rise);
      A_EDGE_FALL: rdata = 32'(edge_fall);
      A_MISC:      rdata = 32'(fpga_misc);
      default:     rdata = addr >= A_ID_BASE ? 32'(id_byte(PADDR[5:2] - 4'd4)) : 32'd0;
    endcase
  end
  assign PRDATA = (PSEL & ~PWRITE) ? rdata : 32'd0;
endmodule

// File: tb/tb_fpga_io_regs_gen.sv
// tb_fpga_io_regs_gen: directed plus randomized checks of the FPGA I/O register block against a bench-side model.
module tb_fpga_io_regs_gen;
  logic PCLK = 1'b0, PRESETn = 1'b0, PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [11:2] PADDR = '0;
  logic [31:0] PWDATA = '0, PRDATA;
  logic PREADY, PSLVERR, clk_100hz = 1'b0, irq;
  logic [1:0] buttons = 2'b00;
  logic [7:0] leds;
  logic [9:0] fpga_misc;
  int total = 0, bad = 0;

  fpga_io_regs_gen dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .clk_100hz(clk_100hz), .buttons(buttons), .leds(leds), .fpga_misc(fpga_misc), .irq(irq)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge PCLK);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    @(negedge PCLK);
    PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = a[11:2]; PWDATA = d;
    @(negedge PCLK);
    PENABLE = 1'b1;
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] d);
    @(negedge PCLK);
    PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = a[11:2];
    #1 d = PRDATA;
    PSEL = 1'b0;
  endtask

  task automatic rdchk(input string tag, input logic [11:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    chk(tag, d, exp);
  endtask

  // One full 100 Hz period per iteration, long enough for the DUT to consume each tick.
  task automatic tk(input int n);
    repeat (n) begin
      @(negedge PCLK) clk_100hz = 1'b1;
      repeat (5) @(negedge PCLK);
      clk_100hz = 1'b0;
      repeat (5) @(negedge PCLK);
    end
  endtask

  logic [11:0] ra [8] = '{12'h000, 12'h04C, 12'h030, 12'h034, 12'h028, 12'h024, 12'h010, 12'h014};
  logic [31:0] rm [8] = '{32'hFF, 32'h3FF, 32'h3, 32'h3, 32'h10003, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
  logic [31:0] model [8] = '{32'h0, 32'h3FF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
  logic [7:0] id_exp [12] = '{8'h04, 8'h00, 8'h00, 8'h00, 8'h51, 8'hB8, 8'h0B, 8'h00, 8'h0D, 8'hF0, 8'h05, 8'hB1};
  logic [11:0] ua [3] = '{12'h038, 12'h040, 12'h100};

  initial begin
    logic [31:0] c0, c1, d, cnt_a, cnt_b;
    int p, k, j;
    cyc(3);
    @(negedge PCLK) PRESETn = 1'b1;
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_leds", 32'(leds), 32'h0);
    chk("rst_misc_out", 32'(fpga_misc), 32'h3FF);
    chk("pready", 32'(PREADY), 32'h1);
    chk("pslverr", 32'(PSLVERR), 32'h0);
    rdchk("rst_misc", 12'h04C, 32'h3FF);
    rdchk("rst_led", 12'h000, 32'h0);
    rdchk("rst_btn", 12'h008, 32'h0);
    rdchk("rst_int_stat", 12'h02C, 32'h0);
    rdchk("rst_int_en", 12'h028, 32'h0);
    rdchk("rst_compare", 12'h024, 32'h0);
    rdchk("rst_cnt1hz", 12'h010, 32'h0);
    rdchk("rst_cnt100hz", 12'h014, 32'h0);
    rdchk("unmapped_040", 12'h040, 32'h0);
    for (int i = 0; i < 12; i++) rdchk($sformatf("id_%0d", i), 12'hFD0 + 12'(4 * i), 32'(id_exp[i]));
    @(negedge PCLK);
    PSEL = 1'b1; PWRITE = 1'b1; PADDR = 10'h013;
    #1 chk("prdata_on_write", PRDATA, 32'h0);
    PSEL = 1'b0; PWRITE = 1'b0;

    // Random register traffic: RW registers keep only their implemented bits, unmapped writes vanish.
    for (int i = 0; i < 24; i++) begin
      j = $urandom_range(0, 7);
      d = $urandom;
      wr(ra[j], d);
      model[j] = d & rm[j];
      wr(ua[$urandom_range(0, 2)], $urandom);
    end
    for (int i = 0; i < 8; i++) rdchk($sformatf("rw_%03h", ra[i]), ra[i], model[i]);
    for (int i = 0; i < 3; i++) rdchk($sformatf("unmapped_%03h", ua[i]), ua[i], 32'h0);
    chk("leds_out", 32'(leds), model[0]);
    chk("misc_out", 32'(fpga_misc), model[1]);

    // CYCLE advances once every PRESCALE+1 clocks, whatever the phase.
    repeat (4) begin
      p = $urandom_range(0, 7);
      k = $urandom_range(2, 6);
      wr(12'h01C, 32'(p));
      rd(12'h018, c0);
      cyc((p + 1) * k);
      rd(12'h018, c1);
      chk($sformatf("cadence_p%0d_k%0d", p, k), c1 - c0, 32'(k));
    end

    wr(12'h01C, 32'd3);
    wr(12'h024, 32'd5);
    wr(12'h028, 32'h10000);
    wr(12'h02C, 32'hFFFF_FFFF);
    wr(12'h018, 32'd0);
    rdchk("cmp_before", 12'h02C, 32'h0);
    cyc(30);
    rdchk("cmp_hit", 12'h02C, 32'h10000);
    chk("cmp_irq", 32'(irq), 32'h1);
    wr(12'h02C, 32'h10000);
    wr(12'h018, 32'd5);
    cyc(2);
    rdchk("cmp_sw_write", 12'h02C, 32'h0);
    wr(12'h01C, 32'd0);
    wr(12'h018, 32'hFFFF_FFFF);
    rdchk("cycle_wrap", 12'h018, 32'h0);
    cyc(10);
    wr(12'h028, 32'h1);
    wr(12'h02C, 32'hFFFF_FFFF);
    wr(12'h030, 32'h1);
    wr(12'h034, 32'h0);
    chk("irq_idle", 32'(irq), 32'h0);

    buttons = 2'b01;
    tk(2);
    rdchk("deb_2ticks", 12'h008, 32'h0);
    rdchk("deb_raw", 12'h00C, 32'h1);
    rdchk("deb_2ticks_stat", 12'h02C, 32'h0);
    tk(1);
    rdchk("deb_3ticks", 12'h008, 32'h1);
    rdchk("rise_stat", 12'h02C, 32'h1);
    chk("rise_irq", 32'(irq), 32'h1);
    wr(12'h02C, 32'h1);
    rdchk("w1c_stat", 12'h02C, 32'h0);
    chk("w1c_irq", 32'(irq), 32'h0);
    buttons = 2'b00;
    tk(3);
    rdchk("release_btn", 12'h008, 32'h0);
    rdchk("release_no_fall", 12'h02C, 32'h0);

    buttons = 2'b01;
    tk(2);
    buttons = 2'b00;
    tk(1);
    buttons = 2'b01;
    tk(2);
    rdchk("glitch_btn", 12'h008, 32'h0);
    rdchk("glitch_stat", 12'h02C, 32'h0);
    tk(1);
    rdchk("glitch_then_hold", 12'h008, 32'h1);
    wr(12'h034, 32'h1);
    wr(12'h02C, 32'h1);
    buttons = 2'b00;
    tk(3);
    rdchk("fall_stat", 12'h02C, 32'h1);
    wr(12'h02C, 32'h1);

    // The third tick's debounce update lands on the same edge as the W1C beat.
    buttons = 2'b01;
    tk(2);
    @(negedge PCLK) clk_100hz = 1'b1;
    @(negedge PCLK);
    PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = 10'h00B; PWDATA = 32'h1;
    @(negedge PCLK) PENABLE = 1'b1;
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    repeat (3) @(negedge PCLK);
    clk_100hz = 1'b0;
    repeat (5) @(negedge PCLK);
    rdchk("set_beats_w1c", 12'h02C, 32'h1);
    rdchk("set_beats_w1c_btn", 12'h008, 32'h1);

    cnt_a = $urandom;
    cnt_b = 32'hFFFF_FFFF - 32'($urandom_range(0, 60));
    wr(12'h010, cnt_a);
    wr(12'h014, cnt_b);
    tk(99);
    rdchk("cnt1hz_99", 12'h010, cnt_a);
    rdchk("cnt100hz_99", 12'h014, cnt_b + 32'd99);
    tk(1);
    rdchk("cnt1hz_100", 12'h010, cnt_a + 32'd1);
    tk(5);
    rdchk("cnt100hz_105", 12'h014, cnt_b + 32'd105);
    rdchk("cnt1hz_105", 12'h010, cnt_a + 32'd1);

    buttons = 2'b00;
    tk(3);
    buttons = 2'b01;
    tk(2);
    @(negedge PCLK) PRESETn = 1'b0;
    cyc(2);
    @(negedge PCLK) PRESETn = 1'b1;
    rdchk("rst2_misc", 12'h04C, 32'h3FF);
    rdchk("rst2_stat", 12'h02C, 32'h0);
    wr(12'h030, 32'h1);
    tk(2);
    rdchk("rst2_progress_lost", 12'h008, 32'h0);
    rdchk("rst2_no_edge", 12'h02C, 32'h0);
    tk(1);
    rdchk("rst2_deb", 12'h008, 32'h1);
    rdchk("rst2_rise", 12'h02C, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fpga_io_regs_gen.md
FPGA_IO_REGS_GEN -- requirements
Module: fpga_io_regs_gen

Interface
- REQ-001 Parameter N_LED, default 8, LED outputs, range 1..32.
- REQ-002 Parameter N_BTN, default 2, button inputs, range 1..16.
- REQ-003 Parameter N_MISC, default 10, misc outputs, range 1..32.
- REQ-004 Parameter DEBOUNCE_TICKS, default 3, 100 Hz ticks of stability required, range 0..15; 0 = bypass.
- REQ-005 PCLK  in  1  single clock; PRESETn  in  1  reset, asynchronous, active-low.
- REQ-006 PSEL, PENABLE, PWRITE  in  1 each  APB control.
- REQ-007 PADDR  in  [11:2]  word address; PWDATA  in  32  write data.
- REQ-008 PRDATA  out  32; PREADY  out  1, tied 1; PSLVERR  out  1, tied 0.
- REQ-009 clk_100hz  in  1  asynchronous 100 Hz reference; buttons  in  N_BTN  asynchronous.
- REQ-010 leds  out  N_LED; fpga_misc  out  N_MISC; irq  out  1  level, registered.

Function
- REQ-011 Write strobe = PSEL & PWRITE & PENABLE; read data combinational when PSEL & ~PWRITE, else 0; unmapped reads 0; unmapped writes ignored.
- REQ-012 Map: 0x000 LED RW; 0x008 BTN RO debounced; 0x00C BTN_RAW RO synchronised; 0x010 CNT1HZ RW; 0x014 CNT100HZ RW; 0x018 CYCLE RW; 0x01C PRESCALE RW; 0x020 PSCNTR RW; 0x024 COMPARE RW; 0x028 INT_EN RW; 0x02C INT_STAT R/W1C; 0x030 EDGE_RISE RW; 0x034 EDGE_FALL RW; 0x04C MISC RW.
- REQ-013 Registers narrower than 32 bits read zero-extended; write bits above width ignored; INT_EN/INT_STAT use bits [N_BTN-1:0] buttons, bit 16 compare.
- REQ-014 ID space 0xFD0..0xFFC reads PID4..7 = 04,00,00,00; PID0..3 = 51,B8,0B,00; CID0..3 = 0D,F0,05,B1.
- REQ-015 buttons and clk_100hz each pass a 2-flop synchroniser; tick = single-cycle pulse on synchronised clk_100hz rising edge (third flop for edge).
- REQ-016 Per-button debounce: when sync != debounced, counter increments per tick; on reaching DEBOUNCE_TICKS debounced takes sync value, counter clears; sync == debounced clears counter immediately.
- REQ-017 Debounced rising edge sets INT_STAT[i] if EDGE_RISE[i]; falling edge sets it if EDGE_FALL[i]; status set independent of INT_EN.
- REQ-018 CNT100HZ increments per tick; divide-by-100 counter (0..99) increments CNT1HZ on tick at 99; CNT1HZ write loads value and clears divider.
- REQ-019 PSCNTR decrements each cycle, reloads PRESCALE at 0; PRESCALE or PSCNTR write loads PSCNTR with PWDATA.
- REQ-020 CYCLE increments when PSCNTR == 0; all counters wrap 0xFFFFFFFF -> 0.
- REQ-021 INT_STAT[16] set on the cycle CYCLE increments to a value equal to COMPARE; a software write to CYCLE never sets it.
- REQ-022 Software write beats hardware increment on the same cycle.
- REQ-023 Hardware set beats W1C clear on the same cycle for the same bit.
- REQ-024 irq registered: next-cycle value = |(INT_STAT & INT_EN).

Reset
- REQ-025 PRESETn low: LED, BTN, BTN_RAW, all counters, PRESCALE, COMPARE, INT_EN, INT_STAT, EDGE_* = 0; MISC = all ones; synchronisers and debounce counters = 0; irq = 0.
- REQ-026 Reset mid-debounce or mid-count discards progress; no edge event generated on reset release.

Structure
- REQ-027 Package fpga_io_regs_pkg holds register offsets, PID/CID constants, INT_STAT bit positions.
- REQ-028 Sub-module fpga_io_btn_debounce (synchroniser, counter, edge flags) instantiated N_BTN times via generate.

Verification
- REQ-029 EDGE_RISE=1, INT_EN=1, button0 high 3 ticks -> BTN=1 after 3rd tick, INT_STAT=0x1, irq=1 next cycle; W1C 0x1 -> irq=0.
- REQ-030 Button0 glitch 2 ticks then low, DEBOUNCE_TICKS=3 -> BTN stays 0, INT_STAT stays 0.
- REQ-031 PRESCALE=3 -> CYCLE increments every 4 PCLK; COMPARE=5, INT_EN bit16 -> INT_STAT[16]=1 when CYCLE reaches 5.
- REQ-032 CYCLE write 0xFFFFFFFF, PRESCALE=0 -> next cycle reads 0; write COMPARE value directly -> no INT_STAT[16].
- REQ-033 Same-cycle W1C and button edge on bit0 -> INT_STAT[0]=1.
- REQ-034 After reset: MISC reads 0x3FF (N_MISC=10), PID0 reads 0x51, address 0x040 reads 0.
